// File: rtl/difftest_commit_sched_if.sv
// Commit-group and trace-record bundle for the difftest commit scheduler.
// Watchdog port present only when DIFFTEST_SCHED_WATCHDOG_EN is defined.
interface difftest_commit_sched_if #(
  parameter int CONFIG_DW            = 64,
  parameter int CONFIG_P_ISSUE_WIDTH = 1,
  parameter int CONFIG_PC_W          = 30,
  parameter int CONFIG_REG_AW        = 5,
  parameter int CONFIG_INSN_DW       = 32
);
  localparam int IW = 1 << CONFIG_P_ISSUE_WIDTH;

  logic [IW-1:0]                cmt_valid;
  logic [CONFIG_PC_W*IW-1:0]    cmt_pc;
  logic [CONFIG_INSN_DW*IW-1:0] cmt_ins;
  logic [IW-1:0]                cmt_we;
  logic [CONFIG_REG_AW*IW-1:0]  cmt_waddr;
  logic [CONFIG_DW*IW-1:0]      cmt_wdat;
  logic                         cmt_excp;
  logic [31:0]                  cmt_excp_vect;
  logic                         cmt_ready;
  logic                         stall_req;

  logic                            out_valid;
  logic                            out_ready;
  logic [CONFIG_P_ISSUE_WIDTH-1:0] out_lane;
  logic                            out_insn_vld;
  logic [CONFIG_PC_W-1:0]          out_pc;
  logic [CONFIG_INSN_DW-1:0]       out_ins;
  logic                            out_we;
  logic [CONFIG_REG_AW-1:0]        out_waddr;
  logic [CONFIG_DW-1:0]            out_wdat;
  logic                            out_excp;
  logic [31:0]                     out_excp_vect;
  logic [31:0]                     out_seq;
  logic                            overflow;
`ifdef DIFFTEST_SCHED_WATCHDOG_EN
  logic                            wdog_err;
`endif

`ifdef DIFFTEST_SCHED_WATCHDOG_EN
  modport master (
    output cmt_valid, cmt_pc, cmt_ins, cmt_we, cmt_waddr, cmt_wdat,
    output cmt_excp, cmt_excp_vect, out_ready,
    input  cmt_ready, stall_req, out_valid, out_lane, out_insn_vld,
    input  out_pc, out_ins, out_we, out_waddr, out_wdat,
    input  out_excp, out_excp_vect, out_seq, overflow, wdog_err
  );
  modport slave (
    input  cmt_valid, cmt_pc, cmt_ins, cmt_we, cmt_waddr, cmt_wdat,
    input  cmt_excp, cmt_excp_vect, out_ready,
    output cmt_ready, stall_req, out_valid, out_lane, out_insn_vld,
    output out_pc, out_ins, out_we, out_waddr, out_wdat,
    output out_excp, out_excp_vect, out_seq, overflow, wdog_err
  );
`else
  modport master (
    output cmt_valid, cmt_pc, cmt_ins, cmt_we, cmt_waddr, cmt_wdat,
    output cmt_excp, cmt_excp_vect, out_ready,
    input  cmt_ready, stall_req, out_valid, out_lane, out_insn_vld,
    input  out_pc, out_ins, out_we, out_waddr, out_wdat,
    input  out_excp, out_excp_vect, out_seq, overflow
  );
  modport slave (
    input  cmt_valid, cmt_pc, cmt_ins, cmt_we, cmt_waddr, cmt_wdat,
    input  cmt_excp, cmt_excp_vect, out_ready,
    output cmt_ready, stall_req, out_valid, out_lane, out_insn_vld,
    output out_pc, out_ins, out_we, out_waddr, out_wdat,
    output out_excp, out_excp_vect, out_seq, overflow
  );
`endif
endinterface

// File: rtl/difftest_commit_sched.sv
// Commit-trace scheduler: buffers commit groups, emits one record per cycle.
// Optional DIFFTEST_SCHED_WATCHDOG_EN adds a sticky stalled-sink watchdog.
module difftest_commit_sched #(
  parameter int CONFIG_DW            = 64,
  parameter int CONFIG_P_ISSUE_WIDTH = 1,
  parameter int CONFIG_PC_W          = 30,
  parameter int CONFIG_REG_AW        = 5,
  parameter int CONFIG_INSN_DW       = 32,
  parameter int CONFIG_P_DEPTH       = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  difftest_commit_sched_if.slave bus
);
  localparam int IW    = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int DEPTH = 1 << CONFIG_P_DEPTH;
  localparam int PW    = CONFIG_P_DEPTH + 1;
  localparam int LW    = CONFIG_P_ISSUE_WIDTH;
  localparam int DP    = CONFIG_P_DEPTH;

  typedef enum logic {IDLE, EMIT} state_t;

  logic [IW-1:0]                valid_q [DEPTH];
  logic [CONFIG_PC_W*IW-1:0]    pc_q    [DEPTH];
  logic [CONFIG_INSN_DW*IW-1:0] ins_q   [DEPTH];
  logic [IW-1:0]                we_q    [DEPTH];
  logic [CONFIG_REG_AW*IW-1:0]  waddr_q [DEPTH];
  logic [CONFIG_DW*IW-1:0]      wdat_q  [DEPTH];
  logic                         excp_q  [DEPTH];
  logic [31:0]                  vect_q  [DEPTH];

  logic [PW-1:0] wptr, rptr, count;
  state_t        state;
  logic [IW-1:0] mask;
  logic [31:0]   seq;
  logic          ovf;

  logic [DP-1:0] head, head_nx;
  logic          ready, attempt, push;
  logic          vld, fire, last, pop;
  logic [IW-1:0] lowbit;
  logic [LW-1:0] lane;

  assign head    = rptr[DP-1:0];
  assign head_nx = head + DP'(1);
  assign ready   = (count != PW'(DEPTH));
  assign attempt = (|bus.cmt_valid) | bus.cmt_excp;
  assign push    = attempt & ready;
  assign vld     = (state == EMIT);
  assign fire    = vld & bus.out_ready;
  assign lowbit  = mask & (~mask + IW'(1));
  assign last    = ~|(mask & (mask - IW'(1)));
  assign pop     = fire & last;

  assign bus.cmt_ready = ready;
  assign bus.stall_req = ~ready;
  assign bus.out_valid = vld;
  assign bus.out_seq   = seq;
  assign bus.overflow  = ovf;

  // Lowest remaining lane of the head group is the one on the wire.
  always_comb begin
    lane = '0;
    for (int i = IW - 1; i >= 0; i--) begin
      if (mask[i]) lane = LW'(i);
    end
  end

  // Record fields from the head entry; zero whenever nothing is offered.
  always_comb begin
    bus.out_lane      = '0;
    bus.out_insn_vld  = 1'b0;
    bus.out_pc        = '0;
    bus.out_ins       = '0;
    bus.out_we        = 1'b0;
    bus.out_waddr     = '0;
    bus.out_wdat      = '0;
    bus.out_excp      = 1'b0;
    bus.out_excp_vect = '0;
    if (vld) begin
      bus.out_lane     = lane;
      bus.out_insn_vld = |mask;
      bus.out_excp     = excp_q[head] & last;
      if (excp_q[head] & last) bus.out_excp_vect = vect_q[head];
      for (int i = 0; i < IW; i++) begin
        if (|mask && lane == LW'(i)) begin
          bus.out_pc    = pc_q[head][i*CONFIG_PC_W +: CONFIG_PC_W];
          bus.out_ins   = ins_q[head][i*CONFIG_INSN_DW +: CONFIG_INSN_DW];
          bus.out_we    = we_q[head][i];
          bus.out_waddr = waddr_q[head][i*CONFIG_REG_AW +: CONFIG_REG_AW];
          bus.out_wdat  = wdat_q[head][i*CONFIG_DW +: CONFIG_DW];
        end
      end
    end
  end

  // Group storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (push) begin
      valid_q[wptr[DP-1:0]] <= bus.cmt_valid;
      pc_q[wptr[DP-1:0]]    <= bus.cmt_pc;
      ins_q[wptr[DP-1:0]]   <= bus.cmt_ins;
      we_q[wptr[DP-1:0]]    <= bus.cmt_we;
      waddr_q[wptr[DP-1:0]] <= bus.cmt_waddr;
      wdat_q[wptr[DP-1:0]]  <= bus.cmt_wdat;
      excp_q[wptr[DP-1:0]]  <= bus.cmt_excp;
      vect_q[wptr[DP-1:0]]  <= bus.cmt_excp_vect;
    end
  end

  // FIFO bookkeeping and the serializer walking lanes of the head group.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      state <= IDLE;
      mask  <= '0;
      seq   <= '0;
      ovf   <= 1'b0;
    end else begin
      if (attempt & ~ready) ovf <= 1'b1;
      if (push) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      count <= count + PW'(push) - PW'(pop);
      if (fire) seq <= seq + 32'd1;
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state <= EMIT;
            mask  <= valid_q[head];
          end else if (push) begin
            state <= EMIT;
            mask  <= bus.cmt_valid;
          end
        end
        EMIT: begin
          if (pop) begin
            if (count > PW'(1)) begin
              mask <= valid_q[head_nx];
            end else if (push) begin
              mask <= bus.cmt_valid;
            end else begin
              state <= IDLE;
              mask  <= '0;
            end
          end else if (fire) begin
            mask <= mask & ~lowbit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIFFTEST_SCHED_WATCHDOG_EN
  logic [15:0] wcnt;
  logic        wdog;

  assign bus.wdog_err = wdog;

  // Count consecutive refused cycles; latch an error once the count tops out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt <= '0;
      wdog <= 1'b0;
    end else begin
      if (fire) begin
        wcnt <= '0;
      end else if (vld & ~bus.out_ready & (wcnt != 16'hFFFF)) begin
        wcnt <= wcnt + 16'd1;
      end
      if (wcnt == 16'hFFFF) wdog <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_difftest_commit_sched.sv
// Bench for difftest_commit_sched: queue-based record model plus directed
// vectors with literal expectations.
module tb_difftest_commit_sched;
  logic clk;
  logic rst_n;

  difftest_commit_sched_if bus ();

  difftest_commit_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    bit          insn;
    logic [29:0] pc;
    logic [31:0] ins;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdat;
    bit          excp;
    logic [31:0] vect;
  } rec_t;

  rec_t        exp_q[$];
  int          grp_q[$];
  int unsigned m_seq;
  bit          m_ovf;
  bit          armed;
  int          n_err;
  int          n_chk;

  bit   m_rdy, m_fire, m_att;
  int   m_hi, m_n;
  rec_t r;
  rec_t f;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req,
               $time);
    end
  endtask

  // Model: groups become per-record expectations the moment they are pushed.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      grp_q.delete();
      m_seq = 0;
      m_ovf = 0;
      armed = 1;
    end else begin
      m_rdy  = (grp_q.size() != 4);
      m_fire = (exp_q.size() != 0) && (bus.out_ready === 1'b1);
      m_att  = (|bus.cmt_valid) || bus.cmt_excp;
      if (m_fire) begin
        void'(exp_q.pop_front());
        m_seq++;
        grp_q[0] = grp_q[0] - 1;
        if (grp_q[0] == 0) void'(grp_q.pop_front());
      end
      if (m_att && !m_rdy) m_ovf = 1;
      if (m_att && m_rdy) begin
        m_hi = -1;
        m_n  = 0;
        for (int i = 0; i < 2; i++) if (bus.cmt_valid[i]) m_hi = i;
        if (m_hi < 0) begin
          r.lane = 0; r.insn = 0; r.pc = '0; r.ins = '0; r.we = 0;
          r.waddr = '0; r.wdat = '0; r.excp = 1;
          r.vect = bus.cmt_excp_vect;
          exp_q.push_back(r);
          m_n = 1;
        end else begin
          for (int i = 0; i < 2; i++) begin
            if (bus.cmt_valid[i]) begin
              r.lane  = i;
              r.insn  = 1;
              r.pc    = bus.cmt_pc[i*30 +: 30];
              r.ins   = bus.cmt_ins[i*32 +: 32];
              r.we    = bus.cmt_we[i];
              r.waddr = bus.cmt_waddr[i*5 +: 5];
              r.wdat  = bus.cmt_wdat[i*64 +: 64];
              r.excp  = bus.cmt_excp && (i == m_hi);
              r.vect  = bus.cmt_excp_vect;
              exp_q.push_back(r);
              m_n++;
            end
          end
        end
        grp_q.push_back(m_n);
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("cmt_ready", 64'(bus.cmt_ready), 64'(grp_q.size() != 4));
      chk("stall_req", 64'(bus.stall_req), 64'(grp_q.size() == 4));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        f = exp_q[0];
        chk("out_seq", 64'(bus.out_seq), 64'(m_seq));
        chk("out_lane", 64'(bus.out_lane), 64'(f.lane));
        chk("out_insn_vld", 64'(bus.out_insn_vld), 64'(f.insn));
        chk("out_excp", 64'(bus.out_excp), 64'(f.excp));
        if (f.excp) chk("out_excp_vect", 64'(bus.out_excp_vect), 64'(f.vect));
        if (f.insn) begin
          chk("out_pc", 64'(bus.out_pc), 64'(f.pc));
          chk("out_ins", 64'(bus.out_ins), 64'(f.ins));
          chk("out_we", 64'(bus.out_we), 64'(f.we));
          chk("out_waddr", 64'(bus.out_waddr), 64'(f.waddr));
          chk("out_wdat", bus.out_wdat, f.wdat);
        end
      end
    end
  end

  task automatic rand_fields();
    logic [63:0] a, b;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    bus.cmt_pc        = {a[29:0], b[29:0]};
    bus.cmt_ins       = {$urandom, $urandom};
    bus.cmt_we        = a[63:62];
    bus.cmt_waddr     = b[63:54];
    bus.cmt_wdat      = {a, b};
    bus.cmt_excp_vect = $urandom;
  endtask

  task automatic idle_in();
    bus.cmt_valid = '0;
    bus.cmt_excp  = 1'b0;
  endtask

  task automatic push_grp(input logic [1:0] v, input logic e,
                          input logic [31:0] vect, input logic [29:0] base);
    rand_fields();
    bus.cmt_pc        = {base + 30'd1, base};
    bus.cmt_valid     = v;
    bus.cmt_excp      = e;
    bus.cmt_excp_vect = vect;
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk(name, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int sent;
    int cyc;
    logic [1:0] v;
    logic e;
    n_err = 0;
    n_chk = 0;
    armed = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    rand_fields();
    bus.cmt_valid = 2'b11;
    bus.cmt_excp  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_in();
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_cmt_ready", 64'(bus.cmt_ready), 64'd1);
    chk("rst_out_seq", 64'(bus.out_seq), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);

    // Full group, two records back to back.
    @(posedge clk);
    #1;
    push_grp(2'b11, 1'b0, 32'h0, 30'h100);
    @(negedge clk);
    chk("g1_pc0", 64'(bus.out_pc), 64'h100);
    chk("g1_seq0", 64'(bus.out_seq), 64'd0);
    chk("g1_lane0", 64'(bus.out_lane), 64'd0);
    @(negedge clk);
    chk("g1_pc1", 64'(bus.out_pc), 64'h101);
    chk("g1_seq1", 64'(bus.out_seq), 64'd1);
    chk("g1_lane1", 64'(bus.out_lane), 64'd1);
    @(negedge clk);
    chk("g1_empty", 64'(bus.out_valid), 64'd0);

    // Sparse group with exception, then an exception-only group.
    @(posedge clk);
    #1;
    push_grp(2'b10, 1'b1, 32'h20, 30'h200);
    @(negedge clk);
    chk("sp_lane", 64'(bus.out_lane), 64'd1);
    chk("sp_excp", 64'(bus.out_excp), 64'd1);
    chk("sp_vect", 64'(bus.out_excp_vect), 64'h20);
    chk("sp_pc", 64'(bus.out_pc), 64'h201);
    @(posedge clk);
    #1;
    push_grp(2'b00, 1'b1, 32'h44, 30'h0);
    @(negedge clk);
    chk("xo_insn_vld", 64'(bus.out_insn_vld), 64'd0);
    chk("xo_excp", 64'(bus.out_excp), 64'd1);
    chk("xo_lane", 64'(bus.out_lane), 64'd0);
    chk("xo_vect", 64'(bus.out_excp_vect), 64'h44);
    chk("xo_seq", 64'(bus.out_seq), 64'd3);
    drain("drain_excp");

    // Fill the FIFO, then overflow it.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int g = 0; g < 4; g++) push_grp(2'b11, 1'b0, 32'h0, 30'(32'h500 + g * 16));
    @(negedge clk);
    chk("full_cmt_ready", 64'(bus.cmt_ready), 64'd0);
    chk("full_stall_req", 64'(bus.stall_req), 64'd1);
    chk("full_overflow0", 64'(bus.overflow), 64'd0);
    @(posedge clk);
    #1;
    push_grp(2'b01, 1'b0, 32'h0, 30'h5F0);
    @(negedge clk);
    chk("full_overflow1", 64'(bus.overflow), 64'd1);
    chk("full_head_pc", 64'(bus.out_pc), 64'h500);
    drain("drain_full");

    // Random backpressure over 200 groups.
    sent = 0;
    cyc  = 0;
    while (sent < 200 && cyc < 8000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (grp_q.size() < 4) begin
        rand_fields();
        v = 2'($urandom_range(0, 3));
        e = ($urandom_range(0, 4) == 0);
        if (v == 2'b00) e = 1'b1;
        bus.cmt_valid = v;
        bus.cmt_excp  = e;
        sent++;
      end else begin
        idle_in();
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    idle_in();
    chk("bp_all_sent", 64'(sent), 64'd200);
    drain("drain_bp");

    // Reset mid-group: lane 1 must never appear.
    @(posedge clk);
    #1;
    push_grp(2'b11, 1'b0, 32'h0, 30'h300);
    @(negedge clk);
    chk("mr_pc0", 64'(bus.out_pc), 64'h300);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_out_seq", 64'(bus.out_seq), 64'd0);
    chk("mr_overflow", 64'(bus.overflow), 64'd0);
    @(posedge clk);
    #1;
    push_grp(2'b01, 1'b0, 32'h0, 30'h400);
    @(negedge clk);
    chk("mr_new_pc", 64'(bus.out_pc), 64'h400);
    chk("mr_new_seq", 64'(bus.out_seq), 64'd0);
    drain("drain_mr");

`ifdef DIFFTEST_SCHED_WATCHDOG_EN
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    push_grp(2'b01, 1'b0, 32'h0, 30'h600);
    repeat (60000) @(posedge clk);
    @(negedge clk);
    chk("wdog_early", 64'(bus.wdog_err), 64'd0);
    repeat (5600) @(posedge clk);
    @(negedge clk);
    chk("wdog_set", 64'(bus.wdog_err), 64'd1);
    drain("drain_wdog");
    chk("wdog_sticky", 64'(bus.wdog_err), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/difftest_commit_sched.md
Name: difftest_commit_sched

Overview:
- Commit-trace scheduler between the commit stage and the difftest commit sink.
- Buffers one commit group per cycle; a group holds up to IW lanes plus a group-level exception.
- Serializes the buffered lanes as one record per cycle over a valid/ready handshake, in lane order.
- Asserts a stall request back to the pipeline when the buffer cannot take another group.

Parameters:
- CONFIG_DW, 64, register write-data width
- CONFIG_P_ISSUE_WIDTH, 1, log2 of issue width; IW = 1<<CONFIG_P_ISSUE_WIDTH
- CONFIG_PC_W, 30, word-address PC width
- CONFIG_REG_AW, 5, register address width
- CONFIG_INSN_DW, 32, instruction width
- CONFIG_P_DEPTH, 2, log2 of group FIFO depth; DEPTH = 1<<CONFIG_P_DEPTH

Ports:
- clk  in  1  clock; every state element updates on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmt_valid  in  IW  per-lane commit valid
- cmt_pc  in  CONFIG_PC_W*IW  per-lane PC
- cmt_ins  in  CONFIG_INSN_DW*IW  per-lane instruction
- cmt_we  in  IW  per-lane register write enable
- cmt_waddr  in  CONFIG_REG_AW*IW  per-lane destination register
- cmt_wdat  in  CONFIG_DW*IW  per-lane write data
- cmt_excp  in  1  group exception taken
- cmt_excp_vect  in  32  exception vector
- cmt_ready  out  1  buffer can accept a group
- stall_req  out  1  = ~cmt_ready
- out_valid  out  1  record available
- out_ready  in  1  sink accepts record
- out_lane  out  CONFIG_P_ISSUE_WIDTH  source lane index
- out_insn_vld  out  1  record carries a retired instruction
- out_pc / out_ins / out_we / out_waddr / out_wdat  out  widths as inputs  record fields
- out_excp  out  1  exception marker; set only on the last record of a group
- out_excp_vect  out  32  valid when out_excp=1
- out_seq  out  32  running record sequence number
- overflow  out  1  sticky; a push was attempted while full

Behaviour:
- Push: a group is pushed when (|cmt_valid | cmt_excp) & cmt_ready. Groups with no valid lane and cmt_excp=0 are never pushed.
- cmt_ready = (count != DEPTH). It depends on registered count only; a same-cycle pop does not make a full FIFO ready.
- Push attempted while full: the group is dropped and overflow is set. overflow clears only on reset.
- FIFO: registered storage, DEPTH entries, pointers CONFIG_P_DEPTH+1 bits wide, wrap modulo DEPTH. count 0..DEPTH.
- Latency: a group pushed in cycle N can present its first record on out_* at cycle N+1 at the earliest. There is no bypass.
- Serializer FSM:
  - IDLE: entered when the FIFO is empty; out_valid=0. Moves to EMIT when count != 0.
  - EMIT: presents the head group's current lane, selected as the lowest set bit of the remaining-lane mask.
  - On out_valid & out_ready, that lane's bit is cleared.
  - When the last record of the group is accepted, the head is popped and the remaining-lane mask reloads from the next entry, or the FSM returns to IDLE if the FIFO is empty.
  - Back-to-back groups stream with no bubble.
- Exception-only group (cmt_valid=0, cmt_excp=1): emits exactly one record with out_insn_vld=0, out_lane=0, out_excp=1.
- Group with valid lanes and cmt_excp=1: the exception is attached to the record of the highest valid lane.
- Handshake: while out_valid=1 and out_ready=0, every out_* field holds stable.
- out_seq: starts at 0 and increments by 1 on each accepted record, wrapping at 2^32.
- Simultaneous push and pop when not full: count is unchanged and both complete.
- Reset, applied at any time including mid-group: pointers, count, FSM (to IDLE), lane mask, out_seq and overflow are cleared. out_valid=0, cmt_ready=1, stall_req=0. Partially emitted groups are discarded.
- Data outputs are don't-care while out_valid=0; the implementation drives them to 0.

Optional Feature:
- Macro DIFFTEST_SCHED_WATCHDOG_EN adds output port wdog_err (1 bit, sticky) and a 16-bit counter.
- The counter increments each cycle that out_valid & ~out_ready, and clears on any accepted record or on reset.
- When the counter reaches 16'hFFFF, wdog_err sets. It clears only on reset.
- Without the macro: no port, no counter; behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> out_valid=0, cmt_ready=1, out_seq=0, overflow=0.
- IW=2, one group cmt_valid=2'b11, pc 0x100/0x101, out_ready=1 -> records lane0 (pc 0x100, seq 0) then lane1 (pc 0x101, seq 1) on consecutive cycles; FIFO empty after.
- Sparse plus exception: cmt_valid=2'b10, cmt_excp=1, vect 0x20 -> single record with lane=1, out_excp=1, out_excp_vect=0x20. Then an exception-only group -> one record with out_insn_vld=0, out_excp=1.
- Full and overflow: out_ready=0, push 4 groups (DEPTH=4) -> cmt_ready=0, stall_req=1. A 5th push sets overflow=1; the first 4 groups are later emitted intact.
- Backpressure: toggle out_ready pseudo-randomly over 200 groups -> fields stable while stalled, no loss or duplication, out_seq contiguous.
- Reset mid-group after lane0 is accepted -> lane1 is never emitted; out_seq=0 afterwards. With DIFFTEST_SCHED_WATCHDOG_EN: hold out_ready=0 for 65535 cycles -> wdog_err=1.
